// File: rtl/arbitro_rr_pkg.sv
// Shared encodings and constants for the round-robin arbiter of the 4-channel mux/demux path.
package arbitro_pkg;
    localparam int NUM_CH   = 4;
    localparam int SEL_BITS = 2;

    // Destination field positions for the default 4-bit word; the top derives them from DATA_BITS.
    localparam int DATA_BITS_DEF = 4;
    localparam int DEST_MSB      = DATA_BITS_DEF - 1;
    localparam int DEST_LSB      = DATA_BITS_DEF - SEL_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEL   = 2'd1,
        CHECK = 2'd2,
        XFER  = 2'd3
    } arb_state_t;

    function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_BITS-1:0] idx);
        logic [NUM_CH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction
endpackage

// File: rtl/arbitro_rr_if.sv
// Control/status bundle between the arbiter and the FIFO banks plus mux/demux datapath.
interface arbitro_rr_if #(parameter int DATA_BITS = 4);
    logic                 enb;
    logic [3:0]           fifo_empty;
    logic [3:0]           almost_full;
    logic [DATA_BITS-1:0] dato_mux;
    logic [1:0]           selectorMux;
    logic [1:0]           selectorDemux;
    logic [3:0]           pop;
    logic [3:0]           push;

    modport master (
        input  enb, fifo_empty, almost_full, dato_mux,
        output selectorMux, selectorDemux, pop, push
    );

    modport slave (
        output enb, fifo_empty, almost_full, dato_mux,
        input  selectorMux, selectorDemux, pop, push
    );
endinterface

// File: rtl/arbitro_rr_prioridad.sv
// Combinational round-robin search: first requester after i_ptr, wrapping, i_ptr itself last.
module rr_prioridad
    import arbitro_pkg::*;
(
    input  logic [SEL_BITS-1:0] i_ptr,
    input  logic [NUM_CH-1:0]   i_req,
    output logic [SEL_BITS-1:0] o_grant,
    output logic                o_valid
);
    logic [SEL_BITS-1:0] w_idx;

    // Walk from the farthest offset back to ptr+1 so the nearest requester is the last to write.
    always_comb begin
        o_grant = i_ptr;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            w_idx = i_ptr + SEL_BITS'(k);
            if (i_req[w_idx]) begin
                o_grant = w_idx;
                o_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/arbitro_rr.sv
// Round-robin arbiter: selects an input FIFO, checks destination space, then issues one-cycle pop/push.
module arbitro_rr
    import arbitro_pkg::*;
#(
    parameter int DATA_BITS = 4
)(
    input  logic          clk,
    input  logic          reset,
    arbitro_rr_if.master  bus
);
    arb_state_t          r_state, w_nxt_state;
    logic [SEL_BITS-1:0] r_ptr, w_nxt_ptr;
    logic [SEL_BITS-1:0] r_sel_mux, w_nxt_sel_mux;
    logic [SEL_BITS-1:0] r_sel_demux, w_nxt_sel_demux;
    logic [NUM_CH-1:0]   r_pop, w_nxt_pop;
    logic [NUM_CH-1:0]   r_push, w_nxt_push;

    logic [SEL_BITS-1:0] w_grant;
    logic                w_valid;
    logic [SEL_BITS-1:0] w_dest;

    assign w_dest = bus.dato_mux[DATA_BITS-1 -: SEL_BITS];

    rr_prioridad u_prio (
        .i_ptr   (r_ptr),
        .i_req   (~bus.fifo_empty),
        .o_grant (w_grant),
        .o_valid (w_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ptr       <= 2'd3;
            r_sel_mux   <= '0;
            r_sel_demux <= '0;
            r_pop       <= '0;
            r_push      <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_ptr       <= w_nxt_ptr;
            r_sel_mux   <= w_nxt_sel_mux;
            r_sel_demux <= w_nxt_sel_demux;
            r_pop       <= w_nxt_pop;
            r_push      <= w_nxt_push;
        end
    end

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_ptr       = r_ptr;
        w_nxt_sel_mux   = r_sel_mux;
        w_nxt_sel_demux = r_sel_demux;
        w_nxt_pop       = '0;
        w_nxt_push      = '0;
        case (r_state)
            IDLE: begin
                if (bus.enb && w_valid) begin
                    w_nxt_sel_mux = w_grant;
                    w_nxt_state   = SEL;
                end
            end
            SEL: w_nxt_state = CHECK;
            CHECK: begin
                // Empty flag is re-read here so a FIFO drained meanwhile is never popped twice.
                if (!bus.enb || bus.fifo_empty[r_sel_mux]) begin
                    w_nxt_state = IDLE;
                end else if (bus.almost_full[w_dest]) begin
                    w_nxt_ptr   = r_sel_mux;
                    w_nxt_state = IDLE;
                end else begin
                    w_nxt_pop       = onehot(r_sel_mux);
                    w_nxt_push      = onehot(w_dest);
                    w_nxt_sel_demux = w_dest;
                    w_nxt_ptr       = r_sel_mux;
                    w_nxt_state     = XFER;
                end
            end
            XFER: begin
                if (bus.enb && w_valid) begin
                    w_nxt_sel_mux = w_grant;
                    w_nxt_state   = SEL;
                end else begin
                    w_nxt_state = IDLE;
                end
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    assign bus.selectorMux   = r_sel_mux;
    assign bus.selectorDemux = r_sel_demux;
    assign bus.pop           = r_pop;
    assign bus.push          = r_push;
endmodule

// File: doc/arbitro_rr.md
Name: arbitro_rr

Overview:
- Round-robin arbiter and control unit for the 4-channel mux/demux datapath.
- Watches four input-FIFO empty flags and four output-FIFO almost-full flags.
- Drives the mux selector, reads the selected head word back from the mux output, decodes its destination, then drives the demux selector together with one-cycle pop/push strobes.
- Sits between the input FIFO bank and the output FIFO bank; mux and demux stay combinational.

Parameters:
- DATA_BITS, 4: word width; bits [DATA_BITS-1:DATA_BITS-2] of a word carry the destination channel.
- NUM_CH, 4: number of channels; fixed at 4 (2-bit selectors).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- enb  input  1  arbiter enable; when 0, no new grants.
- fifo_empty  input  4  empty flag of input FIFO i at bit i.
- almost_full  input  4  almost-full flag of output FIFO i at bit i.
- dato_mux  input  DATA_BITS  mux output (head word of the selected input FIFO).
- selectorMux  output  2  registered mux select.
- selectorDemux  output  2  registered demux select.
- pop  output  4  one-hot pop strobe to the input FIFOs.
- push  output  4  one-hot push strobe to the output FIFOs.

Behaviour:
- Reset, when reset=1 at an edge:
  - state=IDLE; selectorMux=0, selectorDemux=0, pop=0, push=0.
  - Last-grant pointer ptr=3, so the first grant goes to channel 0.
  - A reset asserted mid-transfer wins: the next cycle shows pop=push=0.
- FSM states: IDLE, SEL, CHECK, XFER. Encoding is 2 bits.
- Candidate search (round robin):
  - Scan channels ptr+1, ptr+2, ptr+3, ptr, all mod 4.
  - Pick the first channel c with fifo_empty[c]=0.
- IDLE:
  - pop=push=0.
  - If enb=1 and any fifo_empty bit is 0: register selectorMux=c and go to SEL.
  - Otherwise stay in IDLE.
- SEL:
  - One settle cycle for the mux path; selectorMux holds.
  - Go to CHECK unconditionally.
- CHECK, with d = dato_mux[DATA_BITS-1:DATA_BITS-2]:
  - If enb=0, or fifo_empty[selectorMux]=1: go to IDLE, no strobes, ptr unchanged.
  - Else if almost_full[d]=1 (destination blocked): ptr=selectorMux (channel skipped this round), go to IDLE, no strobes.
  - Else: register pop=onehot(selectorMux), push=onehot(d), selectorDemux=d, ptr=selectorMux, go to XFER.
- XFER:
  - pop/push are high for exactly this one cycle; selectorMux and selectorDemux hold, so data flows mux to demux.
  - Next edge: strobes clear.
  - Once entered, XFER always completes; enb=0 does not abort it.
  - Next-state scan uses the updated ptr:
    - if enb=1 and a candidate exists, go to SEL with the new selectorMux;
    - else go to IDLE.
- Timing:
  - Throughput is 1 word per 3 cycles under continuous traffic.
  - Latency from fifo_empty falling (IDLE) to pop high is 3 edges.
- selectorDemux changes only on entry to XFER; it holds its last value otherwise.
- Invariants:
  - pop and push are each one-hot or zero.
  - pop and push are never high outside XFER.
- Boundary cases:
  - Single-word FIFO: a fresh empty flag is rechecked in CHECK, so the same channel is never double-popped.
  - Pointer wrap: after 3 the scan continues at 0.
  - All four FIFOs non-empty: the strict grant order is 0,1,2,3,0.

Decomposition:
- Package arbitro_pkg holds:
  - state encodings IDLE=0, SEL=1, CHECK=2, XFER=3;
  - NUM_CH=4, SEL_BITS=2;
  - DEST_MSB/DEST_LSB field positions.
- Sub-module rr_prioridad: combinational. Inputs are ptr[1:0] and req[3:0] (~fifo_empty). Outputs are grant index [1:0] and a valid bit.
- The FSM, pointer and output registers stay in arbitro_rr.

Test Plan:
- Reset check: reset=1 for 2 cycles with traffic present -> selectorMux=0, selectorDemux=0, pop=0, push=0, state IDLE.
- Single transfer: fifo_empty=4'b1101, dato_mux=4'b1110 (dest 3), almost_full=0 -> selectorMux=1 after edge 1; pop=4'b0010, push=4'b1000, selectorDemux=3 on edge 3 for one cycle only.
- Round robin: fifo_empty=4'b0000 held, almost_full=0, dato_mux=4'b0010 (dest 0) -> pop sequence 0001, 0010, 0100, 1000, 0001, spaced 3 cycles apart.
- Blocked destination: fifo_empty=4'b1110, dato_mux=4'b1011 (dest 2), almost_full=4'b0100 -> no pop/push. Drop almost_full to 0 -> pop=0001, push=0100.
- Enable gating: enb=0 with fifo_empty=0000 -> pop/push stay 0. Set enb=1 -> first grant goes to channel 0. Drop enb during XFER -> that strobe completes, then IDLE.
- Empty race: fifo_empty[2] rises during SEL for channel 2 -> CHECK issues no strobes and the FSM returns to IDLE.
